// File: rtl/pipelined_control_unit_if.sv
// Bus between the IF/ID stage, the decode control unit and the ID/EX consumers.
// Carries the instruction handshake in and the registered control bundle out.
interface pipelined_control_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALUCTRL_WIDTH  = 5,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  // Handshake: instr_valid_i qualifies instr_i; hazard_stall_o is the inverse of ready.
  // While hazard_stall_o is high the producer must hold instr_i and instr_valid_i
  // unchanged, and the instruction counts as accepted on the first edge where it is low.
  logic [DATA_WIDTH-1:0]     instr_i;
  logic                      instr_valid_i;
  logic                      flush_i;
  logic                      stall_ext_i;
  logic                      hazard_stall_o;
  logic                      ex_valid_o;
  logic                      ex_reg_write_o;
  logic                      ex_mem_read_o;
  logic                      ex_mem_write_o;
  logic                      ex_branch_o;
  logic                      ex_jump_o;
  logic                      ex_illegal_o;
  logic [ALUCTRL_WIDTH-1:0]  ex_alu_ctrl_o;
  logic [2:0]                ex_imm_src_o;
  logic [1:0]                ex_pc_src_o;
  logic                      ex_alu_src_b_o;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_o;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_o;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_o;
  logic [2:0]                ex_funct3_o;
  logic [CNT_WIDTH-1:0]      bubble_cnt_o;

  modport slave (
    input  instr_i, instr_valid_i, flush_i, stall_ext_i,
    output hazard_stall_o, ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
           ex_branch_o, ex_jump_o, ex_illegal_o, ex_alu_ctrl_o, ex_imm_src_o, ex_pc_src_o,
           ex_alu_src_b_o, ex_rd_o, ex_rs1_o, ex_rs2_o, ex_funct3_o, bubble_cnt_o
  );

  modport master (
    output instr_i, instr_valid_i, flush_i, stall_ext_i,
    input  hazard_stall_o, ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
           ex_branch_o, ex_jump_o, ex_illegal_o, ex_alu_ctrl_o, ex_imm_src_o, ex_pc_src_o,
           ex_alu_src_b_o, ex_rd_o, ex_rs1_o, ex_rs2_o, ex_funct3_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32I(+M) decode-stage control: decodes IF/ID, registers ID/EX controls,
// detects load-use hazards and counts the bubbles they cost (saturating).
module pipelined_control_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALUCTRL_WIDTH  = 5,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ENABLE_M       = 0,
  parameter int CNT_WIDTH      = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  pipelined_control_unit_if.slave  bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD   = ALUCTRL_WIDTH'(0);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB   = ALUCTRL_WIDTH'(1);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND   = ALUCTRL_WIDTH'(2);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR    = ALUCTRL_WIDTH'(3);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_XOR   = ALUCTRL_WIDTH'(4);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLL   = ALUCTRL_WIDTH'(5);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRL   = ALUCTRL_WIDTH'(6);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRA   = ALUCTRL_WIDTH'(7);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT   = ALUCTRL_WIDTH'(8);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLTU  = ALUCTRL_WIDTH'(9);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_PASSB = ALUCTRL_WIDTH'(10);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_MUL   = ALUCTRL_WIDTH'(16);

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      branch;
    logic                      jump;
    logic                      illegal;
    logic [ALUCTRL_WIDTH-1:0]  alu_ctrl;
    logic [2:0]                imm_src;
    logic [1:0]                pc_src;
    logic                      alu_src_b;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [2:0]                funct3;
  } ctrl_t;

  function automatic logic [ALUCTRL_WIDTH-1:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  ctrl_t      dec;
  ctrl_t      ex_q;
  logic       rs1_used;
  logic       rs2_used;
  logic       legal;
  logic       hazard;
  logic [CNT_WIDTH-1:0] bubble_cnt;

  assign opcode = bus.instr_i[6:0];
  assign funct3 = bus.instr_i[14:12];
  assign funct7 = bus.instr_i[31:25];

  always_comb begin
    dec          = '0;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    legal        = 1'b1;
    dec.valid    = 1'b1;
    dec.rd       = REG_ADDR_WIDTH'(bus.instr_i[11:7]);
    dec.rs1      = REG_ADDR_WIDTH'(bus.instr_i[19:15]);
    dec.rs2      = REG_ADDR_WIDTH'(bus.instr_i[24:20]);
    dec.funct3   = funct3;
    case (opcode)
      OP_R: begin
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000)
          dec.alu_ctrl = base_op(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000)
          dec.alu_ctrl = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101)
          dec.alu_ctrl = ALU_SRA;
        else if (funct7 == 7'b0000001 && ENABLE_M != 0)
          dec.alu_ctrl = ALU_MUL | ALUCTRL_WIDTH'(funct3);
        else
          legal = 1'b0;
      end
      OP_IMM: begin
        rs1_used      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        // Only shifts carry a funct7; for the rest those bits are immediate.
        if (funct3 == 3'b101 && funct7 == 7'b0100000)
          dec.alu_ctrl = ALU_SRA;
        else if ((funct3 == 3'b001 || funct3 == 3'b101) && funct7 != 7'b0000000)
          legal = 1'b0;
        else
          dec.alu_ctrl = base_op(funct3);
      end
      OP_LOAD: begin
        rs1_used      = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_src_b = 1'b1;
      end
      OP_STORE: begin
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm_src   = 3'd1;
      end
      OP_BRANCH: begin
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        dec.imm_src  = 3'd2;
        dec.pc_src   = 2'd1;
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.imm_src   = 3'd4;
        dec.pc_src    = 2'd1;
      end
      OP_JALR: begin
        rs1_used      = 1'b1;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.pc_src    = 2'd2;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_ctrl  = ALU_PASSB;
        dec.imm_src   = 3'd3;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm_src   = 3'd3;
      end
      default: legal = 1'b0;
    endcase
    // Illegal ops keep their register fields for trap reporting but enable nothing.
    if (!legal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.alu_ctrl  = '0;
      dec.imm_src   = 3'd0;
      dec.pc_src    = 2'd0;
      dec.alu_src_b = 1'b0;
      dec.illegal   = 1'b1;
      rs1_used      = 1'b0;
      rs2_used      = 1'b0;
    end
    if (dec.rd == '0) dec.reg_write = 1'b0;
  end

  assign hazard = bus.instr_valid_i & ~bus.flush_i & ex_q.valid & ex_q.mem_read &
                  (ex_q.rd != '0) &
                  ((rs1_used & (dec.rs1 == ex_q.rd)) | (rs2_used & (dec.rs2 == ex_q.rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      bubble_cnt <= '0;
    end else if (bus.flush_i) begin
      ex_q <= '0;
    end else if (bus.stall_ext_i) begin
      ex_q <= ex_q;
    end else if (hazard) begin
      ex_q <= '0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
    end else if (bus.instr_valid_i) begin
      ex_q <= dec;
    end else begin
      ex_q <= '0;
    end
  end

  assign bus.hazard_stall_o = hazard & ~bus.stall_ext_i;
  assign bus.ex_valid_o     = ex_q.valid;
  assign bus.ex_reg_write_o = ex_q.reg_write;
  assign bus.ex_mem_read_o  = ex_q.mem_read;
  assign bus.ex_mem_write_o = ex_q.mem_write;
  assign bus.ex_branch_o    = ex_q.branch;
  assign bus.ex_jump_o      = ex_q.jump;
  assign bus.ex_illegal_o   = ex_q.illegal;
  assign bus.ex_alu_ctrl_o  = ex_q.alu_ctrl;
  assign bus.ex_imm_src_o   = ex_q.imm_src;
  assign bus.ex_pc_src_o    = ex_q.pc_src;
  assign bus.ex_alu_src_b_o = ex_q.alu_src_b;
  assign bus.ex_rd_o        = ex_q.rd;
  assign bus.ex_rs1_o       = ex_q.rs1;
  assign bus.ex_rs2_o       = ex_q.rs2;
  assign bus.ex_funct3_o    = ex_q.funct3;
  assign bus.bubble_cnt_o   = bubble_cnt;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: three instances (base, RV32M, 2-bit counter)
// share one stimulus stream; ID/EX expectations flow through a scoreboard queue.
module tb_pipelined_control_unit;

  localparam int W = 36;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        ivalid;
  logic        flush;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int cnt_exp = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp;

  localparam logic [31:0] LW5    = 32'h0000A283;
  localparam logic [31:0] LW0    = 32'h0000A003;
  localparam logic [31:0] ADD6_5 = 32'h00128333;
  localparam logic [31:0] SW5    = 32'h0050A023;
  localparam logic [31:0] MUL    = 32'h022081B3;

  always #5 clk = ~clk;

  pipelined_control_unit_if #(.CNT_WIDTH(16)) if_a ();
  pipelined_control_unit_if #(.CNT_WIDTH(16)) if_m ();
  pipelined_control_unit_if #(.CNT_WIDTH(2))  if_c ();

  assign if_a.instr_i = instr;  assign if_a.instr_valid_i = ivalid;
  assign if_a.flush_i = flush;  assign if_a.stall_ext_i   = stall;
  assign if_m.instr_i = instr;  assign if_m.instr_valid_i = ivalid;
  assign if_m.flush_i = flush;  assign if_m.stall_ext_i   = stall;
  assign if_c.instr_i = instr;  assign if_c.instr_valid_i = ivalid;
  assign if_c.flush_i = flush;  assign if_c.stall_ext_i   = stall;

  pipelined_control_unit #(.ENABLE_M(0), .CNT_WIDTH(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  pipelined_control_unit #(.ENABLE_M(1), .CNT_WIDTH(16)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m.slave));
  pipelined_control_unit #(.ENABLE_M(0), .CNT_WIDTH(2))  dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  function automatic logic [W-1:0] pk(input logic v, rw, mr, mw, br, jp, il,
                                      input logic [4:0] alu, input logic [2:0] imm,
                                      input logic [1:0] pc, input logic sb,
                                      input logic [4:0] rd, rs1, rs2, input logic [2:0] f3);
    return {v, rw, mr, mw, br, jp, il, alu, imm, pc, sb, rd, rs1, rs2, f3};
  endfunction

  function automatic logic [W-1:0] obs_a();
    return {if_a.ex_valid_o, if_a.ex_reg_write_o, if_a.ex_mem_read_o, if_a.ex_mem_write_o,
            if_a.ex_branch_o, if_a.ex_jump_o, if_a.ex_illegal_o, if_a.ex_alu_ctrl_o,
            if_a.ex_imm_src_o, if_a.ex_pc_src_o, if_a.ex_alu_src_b_o, if_a.ex_rd_o,
            if_a.ex_rs1_o, if_a.ex_rs2_o, if_a.ex_funct3_o};
  endfunction

  function automatic logic [W-1:0] obs_m();
    return {if_m.ex_valid_o, if_m.ex_reg_write_o, if_m.ex_mem_read_o, if_m.ex_mem_write_o,
            if_m.ex_branch_o, if_m.ex_jump_o, if_m.ex_illegal_o, if_m.ex_alu_ctrl_o,
            if_m.ex_imm_src_o, if_m.ex_pc_src_o, if_m.ex_alu_src_b_o, if_m.ex_rd_o,
            if_m.ex_rs1_o, if_m.ex_rs2_o, if_m.ex_funct3_o};
  endfunction

  // clock/reset and drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [31:0] i, input logic v, input logic f, input logic s);
    instr  = i;
    ivalid = v;
    flush  = f;
    stall  = s;
    #1;
  endtask

  task automatic idle();
    apply(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    checks++;
    if (obs_a() !== '0) begin errors++; $display("FAIL reset_ex: got %h expected %h", obs_a(), {W{1'b0}}); end
    checks++;
    if (if_a.bubble_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", if_a.bubble_cnt_o); end
    checks++;
    if (if_a.hazard_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", if_a.hazard_stall_o); end
    rst_n = 1'b1;
    cnt_exp = 0;
    exp_q.push_back('0);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs_a(), exp); end
  endtask

  task automatic test_decode();
    logic [31:0]  ti[14];
    logic [W-1:0] te[14];
    ti[0]  = 32'h002081B3; te[0]  = pk(1,1,0,0,0,0,0,  0,0,0,0, 3,1,2,0);
    ti[1]  = LW5;          te[1]  = pk(1,1,1,0,0,0,0,  0,0,0,1, 5,1,0,2);
    ti[2]  = 32'h0020A223; te[2]  = pk(1,0,0,1,0,0,0,  0,1,0,1, 4,1,2,2);
    ti[3]  = 32'h00208463; te[3]  = pk(1,0,0,0,1,0,0,  1,2,1,0, 8,1,2,0);
    ti[4]  = 32'h000000EF; te[4]  = pk(1,1,0,0,0,1,0,  0,4,1,0, 1,0,0,0);
    ti[5]  = 32'h00008067; te[5]  = pk(1,0,0,0,0,1,0,  0,0,2,1, 0,1,0,0);
    ti[6]  = 32'h000013B7; te[6]  = pk(1,1,0,0,0,0,0, 10,3,0,1, 7,0,0,1);
    ti[7]  = 32'h00000217; te[7]  = pk(1,1,0,0,0,0,0,  0,3,0,1, 4,0,0,0);
    ti[8]  = 32'h402081B3; te[8]  = pk(1,1,0,0,0,0,0,  1,0,0,0, 3,1,2,0);
    ti[9]  = 32'h4020D1B3; te[9]  = pk(1,1,0,0,0,0,0,  7,0,0,0, 3,1,2,5);
    ti[10] = 32'h4020D193; te[10] = pk(1,1,0,0,0,0,0,  7,0,0,1, 3,1,2,5);
    ti[11] = 32'h0050F193; te[11] = pk(1,1,0,0,0,0,0,  2,0,0,1, 3,1,5,7);
    ti[12] = 32'h0000007F; te[12] = pk(1,0,0,0,0,0,1,  0,0,0,0, 0,0,0,0);
    ti[13] = 32'h402091B3; te[13] = pk(1,0,0,0,0,0,1,  0,0,0,0, 3,1,2,1);
    idle();
    for (int i = 0; i < 14; i++) begin
      apply(ti[i], 1'b1, 1'b0, 1'b0);
      exp_q.push_back(te[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs_a() !== exp) begin errors++; $display("FAIL decode[%0d]: got %h expected %h", i, obs_a(), exp); end
    end
    apply(32'h002081B3, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('0);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL decode_invalid: got %h expected %h", obs_a(), exp); end
  endtask

  task automatic test_load_use();
    idle();
    apply(LW5, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pk(1,1,1,0,0,0,0, 0,0,0,1, 5,1,0,2));
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL lu_load: got %h expected %h", obs_a(), exp); end
    apply(ADD6_5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (if_a.hazard_stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", if_a.hazard_stall_o); end
    exp_q.push_back('0);
    cnt_exp++;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL lu_bubble: got %h expected %h", obs_a(), exp); end
    checks++;
    if (if_a.bubble_cnt_o !== 16'(cnt_exp)) begin errors++; $display("FAIL lu_cnt: got %0d expected %0d", if_a.bubble_cnt_o, cnt_exp); end
    checks++;
    if (if_a.hazard_stall_o !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", if_a.hazard_stall_o); end
    exp_q.push_back(pk(1,1,0,0,0,0,0, 0,0,0,0, 6,5,1,0));
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL lu_decode: got %h expected %h", obs_a(), exp); end
  endtask

  task automatic test_no_hazard();
    logic [31:0]  ld[3];
    logic [W-1:0] le[3];
    logic [31:0]  us[3];
    logic [W-1:0] ue[3];
    ld[0] = LW0; le[0] = pk(1,0,1,0,0,0,0, 0,0,0,1, 0,1,0,2);
    us[0] = 32'h000001B3; ue[0] = pk(1,1,0,0,0,0,0, 0,0,0,0, 3,0,0,0);
    ld[1] = LW5; le[1] = pk(1,1,1,0,0,0,0, 0,0,0,1, 5,1,0,2);
    us[1] = 32'h00208333; ue[1] = pk(1,1,0,0,0,0,0, 0,0,0,0, 6,1,2,0);
    ld[2] = LW5; le[2] = pk(1,1,1,0,0,0,0, 0,0,0,1, 5,1,0,2);
    us[2] = 32'h0002B3B7; ue[2] = pk(1,1,0,0,0,0,0, 10,3,0,1, 7,5,0,3);
    idle();
    for (int i = 0; i < 3; i++) begin
      apply(ld[i], 1'b1, 1'b0, 1'b0);
      exp_q.push_back(le[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs_a() !== exp) begin errors++; $display("FAIL nh_load[%0d]: got %h expected %h", i, obs_a(), exp); end
      apply(us[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (if_a.hazard_stall_o !== 1'b0) begin errors++; $display("FAIL nh_stall[%0d]: got %b expected 0", i, if_a.hazard_stall_o); end
      exp_q.push_back(ue[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs_a() !== exp) begin errors++; $display("FAIL nh_use[%0d]: got %h expected %h", i, obs_a(), exp); end
    end
  endtask

  task automatic test_flush();
    idle();
    for (int s = 0; s < 2; s++) begin
      apply(LW5, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(pk(1,1,1,0,0,0,0, 0,0,0,1, 5,1,0,2));
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs_a() !== exp) begin errors++; $display("FAIL fl_load[%0d]: got %h expected %h", s, obs_a(), exp); end
      apply(ADD6_5, 1'b1, 1'b1, s[0]);
      checks++;
      if (if_a.hazard_stall_o !== 1'b0) begin errors++; $display("FAIL fl_stall[%0d]: got %b expected 0", s, if_a.hazard_stall_o); end
      exp_q.push_back('0);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs_a() !== exp) begin errors++; $display("FAIL fl_bubble[%0d]: got %h expected %h", s, obs_a(), exp); end
      checks++;
      if (if_a.bubble_cnt_o !== 16'(cnt_exp)) begin errors++; $display("FAIL fl_cnt[%0d]: got %0d expected %0d", s, if_a.bubble_cnt_o, cnt_exp); end
    end
  endtask

  task automatic test_stall_ext();
    idle();
    apply(LW5, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pk(1,1,1,0,0,0,0, 0,0,0,1, 5,1,0,2));
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL st_load: got %h expected %h", obs_a(), exp); end
    apply(ADD6_5, 1'b1, 1'b0, 1'b1);
    checks++;
    if (if_a.hazard_stall_o !== 1'b0) begin errors++; $display("FAIL st_stall: got %b expected 0", if_a.hazard_stall_o); end
    exp_q.push_back(pk(1,1,1,0,0,0,0, 0,0,0,1, 5,1,0,2));
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL st_hold: got %h expected %h", obs_a(), exp); end
    checks++;
    if (if_a.bubble_cnt_o !== 16'(cnt_exp)) begin errors++; $display("FAIL st_cnt: got %0d expected %0d", if_a.bubble_cnt_o, cnt_exp); end
    apply(ADD6_5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (if_a.hazard_stall_o !== 1'b1) begin errors++; $display("FAIL st_resume: got %b expected 1", if_a.hazard_stall_o); end
    exp_q.push_back('0);
    cnt_exp++;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL st_bubble: got %h expected %h", obs_a(), exp); end
    exp_q.push_back(pk(1,1,0,0,0,0,0, 0,0,0,0, 6,5,1,0));
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL st_decode: got %h expected %h", obs_a(), exp); end
  endtask

  task automatic test_rv32m();
    idle();
    apply(MUL, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pk(1,0,0,0,0,0,1, 0,0,0,0, 3,1,2,0));
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL m_base_illegal: got %h expected %h", obs_a(), exp); end
    checks++;
    if (obs_m() !== pk(1,1,0,0,0,0,0, 16,0,0,0, 3,1,2,0))
      begin errors++; $display("FAIL m_mul: got %h expected %h", obs_m(), pk(1,1,0,0,0,0,0, 16,0,0,0, 3,1,2,0)); end
    apply(32'h0220B1B3, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pk(1,0,0,0,0,0,1, 0,0,0,0, 3,1,2,3));
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL m_base_mulhu: got %h expected %h", obs_a(), exp); end
    checks++;
    if (obs_m() !== pk(1,1,0,0,0,0,0, 19,0,0,0, 3,1,2,3))
      begin errors++; $display("FAIL m_mulhu: got %h expected %h", obs_m(), pk(1,1,0,0,0,0,0, 19,0,0,0, 3,1,2,3)); end
    apply(32'h0000007F, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pk(1,0,0,0,0,0,1, 0,0,0,0, 0,0,0,0));
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL m_opc_base: got %h expected %h", obs_a(), exp); end
    checks++;
    if (obs_m() !== exp) begin errors++; $display("FAIL m_opc_m: got %h expected %h", obs_m(), exp); end
  endtask

  task automatic test_saturation();
    int sat;
    idle();
    for (int k = 0; k < 5; k++) begin
      apply(LW5, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(pk(1,1,1,0,0,0,0, 0,0,0,1, 5,1,0,2));
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs_a() !== exp) begin errors++; $display("FAIL sat_load[%0d]: got %h expected %h", k, obs_a(), exp); end
      apply((k % 2 == 0) ? ADD6_5 : SW5, 1'b1, 1'b0, 1'b0);
      checks++;
      if (if_a.hazard_stall_o !== 1'b1) begin errors++; $display("FAIL sat_stall[%0d]: got %b expected 1", k, if_a.hazard_stall_o); end
      exp_q.push_back('0);
      cnt_exp++;
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs_a() !== exp) begin errors++; $display("FAIL sat_bubble[%0d]: got %h expected %h", k, obs_a(), exp); end
      sat = (cnt_exp > 3) ? 3 : cnt_exp;
      checks++;
      if (if_c.bubble_cnt_o !== 2'(sat)) begin errors++; $display("FAIL sat_cnt2[%0d]: got %0d expected %0d", k, if_c.bubble_cnt_o, sat); end
      checks++;
      if (if_a.bubble_cnt_o !== 16'(cnt_exp)) begin errors++; $display("FAIL sat_cnt16[%0d]: got %0d expected %0d", k, if_a.bubble_cnt_o, cnt_exp); end
      if (k % 2 == 0) exp_q.push_back(pk(1,1,0,0,0,0,0, 0,0,0,0, 6,5,1,0));
      else            exp_q.push_back(pk(1,0,0,1,0,0,0, 0,1,0,1, 0,1,5,2));
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs_a() !== exp) begin errors++; $display("FAIL sat_use[%0d]: got %h expected %h", k, obs_a(), exp); end
    end
    checks++;
    if (if_c.bubble_cnt_o !== 2'd3) begin errors++; $display("FAIL sat_final: got %0d expected 3", if_c.bubble_cnt_o); end
  endtask

  task automatic test_reset_mid_stall();
    apply(LW5, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pk(1,1,1,0,0,0,0, 0,0,0,1, 5,1,0,2));
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL rs_load: got %h expected %h", obs_a(), exp); end
    apply(ADD6_5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (if_a.hazard_stall_o !== 1'b1) begin errors++; $display("FAIL rs_pending: got %b expected 1", if_a.hazard_stall_o); end
    rst_n = 1'b0;
    cnt_exp = 0;
    #1;
    checks++;
    if (obs_a() !== '0) begin errors++; $display("FAIL rs_async_ex: got %h expected %h", obs_a(), {W{1'b0}}); end
    checks++;
    if (obs_m() !== '0) begin errors++; $display("FAIL rs_async_m: got %h expected %h", obs_m(), {W{1'b0}}); end
    checks++;
    if (if_a.bubble_cnt_o !== 16'd0 || if_c.bubble_cnt_o !== 2'd0)
      begin errors++; $display("FAIL rs_async_cnt: got %0d/%0d expected 0/0", if_a.bubble_cnt_o, if_c.bubble_cnt_o); end
    checks++;
    if (if_a.hazard_stall_o !== 1'b0) begin errors++; $display("FAIL rs_async_stall: got %b expected 0", if_a.hazard_stall_o); end
    rst_n = 1'b1;
    #1;
    exp_q.push_back(pk(1,1,0,0,0,0,0, 0,0,0,0, 6,5,1,0));
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL rs_redecode: got %h expected %h", obs_a(), exp); end
    checks++;
    if (if_a.bubble_cnt_o !== 16'(cnt_exp)) begin errors++; $display("FAIL rs_cnt: got %0d expected %0d", if_a.bubble_cnt_o, cnt_exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_stall_ext();
    test_rv32m();
    test_saturation();
    test_reset_mid_stall();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_empty: got %0d entries expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
